// File: rtl/lockstep_cmp_checker.sv
// Dual-channel lockstep comparator with a mismatch-escalation FSM.
// Channel 0 drives the compare result; channel 1 only cross-checks it.
module lockstep_cmp_checker #(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned FAULT_THRESH = 3,
  parameter int unsigned ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     a0,
  input  logic [WIDTH-1:0]     b0,
  input  logic [WIDTH-1:0]     a1,
  input  logic [WIDTH-1:0]     b1,
  input  logic                 clr_fault,
  output logic                 out_valid,
  output logic                 lt,
  output logic                 gt,
  output logic                 eq,
  output logic                 mismatch,
  output logic                 fault,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAULT   = 2'd2
  } state_e;

  localparam logic [3:0] THRESH = 4'(FAULT_THRESH);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;
  localparam logic [ERR_CNT_W-1:0] ERR_ONE = ERR_CNT_W'(1);

  state_e               state_q, state_d;
  logic [3:0]           run_q, run_d;
  logic [3:0]           run_inc;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic                 vld_q;
  logic                 mm_q;
  logic [2:0]           res_q;
  logic [2:0]           cmp0, cmp1;

  // Per-channel unsigned compare, one-hot {lt,gt,eq}
  always_comb begin
    cmp0 = 3'b001;
    cmp1 = 3'b001;
    if (a0 < b0) cmp0 = 3'b100;
    else if (a0 > b0) cmp0 = 3'b010;
    if (a1 < b1) cmp1 = 3'b100;
    else if (a1 > b1) cmp1 = 3'b010;
  end

  assign run_inc = run_q + 4'd1;

  // Escalation FSM and error counter, advanced by registered samples
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    err_d   = err_q;
    if (state_q == ST_FAULT && clr_fault) begin
      state_d = ST_OK;
      run_d   = 4'd0;
    end else if (vld_q) begin
      unique case (state_q)
        ST_OK: begin
          if (mm_q) begin
            run_d   = 4'd1;
            state_d = (THRESH == 4'd1) ? ST_FAULT : ST_SUSPECT;
          end
        end
        ST_SUSPECT: begin
          if (mm_q) begin
            run_d = run_inc;
            if (run_inc >= THRESH) state_d = ST_FAULT;
          end else begin
            run_d   = 4'd0;
            state_d = ST_OK;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_OK;
          run_d   = 4'd0;
        end
      endcase
    end
    if (vld_q && mm_q && err_q != ERR_MAX) err_d = err_q + ERR_ONE;
  end

  // FSM state, run length and error count registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_OK;
      run_q   <= 4'd0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      err_q   <= err_d;
    end
  end

  // Result stage; results are blanked if the sample lands in FAULT
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_q <= 1'b0;
      mm_q  <= 1'b0;
      res_q <= 3'b000;
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        mm_q  <= |(cmp0 ^ cmp1);
        res_q <= (state_d == ST_FAULT) ? 3'b000 : cmp0;
      end else begin
        mm_q  <= 1'b0;
      end
    end
  end

  assign out_valid = vld_q;
  assign mismatch  = mm_q;
  assign lt        = res_q[2];
  assign gt        = res_q[1];
  assign eq        = res_q[0];
  assign fault     = (state_q == ST_FAULT);
  assign state     = state_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_lockstep_cmp_checker.sv
// Bench for lockstep_cmp_checker: directed table plus random traffic
// against a streak-counting reference model.
module tb_lockstep_cmp_checker;

  localparam int THR = 3;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [3:0] a0, b0, a1, b1;
  logic       clr_fault;

  logic       out_valid, lt, gt, eq, mismatch, fault;
  logic [7:0] err_cnt;
  logic [1:0] state;

  logic       ov2, lt2, gt2, eq2, mm2, flt2;
  logic [1:0] err2;
  logic [1:0] st2;

  lockstep_cmp_checker #(
    .WIDTH(4), .FAULT_THRESH(THR), .ERR_CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .clr_fault(clr_fault),
    .out_valid(out_valid), .lt(lt), .gt(gt), .eq(eq),
    .mismatch(mismatch), .fault(fault),
    .err_cnt(err_cnt), .state(state)
  );

  lockstep_cmp_checker #(
    .WIDTH(4), .FAULT_THRESH(THR), .ERR_CNT_W(2)
  ) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .clr_fault(clr_fault),
    .out_valid(ov2), .lt(lt2), .gt(gt2), .eq(eq2),
    .mismatch(mm2), .fault(flt2),
    .err_cnt(err2), .state(st2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // reference model: streak of consecutive mismatches, sticky fault
  bit       m_fault;
  int       m_streak;
  int       m_err;
  bit       m_pv;
  bit       m_pmm;
  bit [2:0] m_disp;

  function automatic bit [2:0] cmp3(input int x, input int y);
    if (x < y) return 3'b100;
    if (x > y) return 3'b010;
    return 3'b001;
  endfunction

  function automatic int min3(input int x);
    return (x > 3) ? 3 : x;
  endfunction

  task automatic model_step();
    if (!reset) begin
      m_fault = 0; m_streak = 0; m_err = 0;
      m_pv = 0; m_pmm = 0; m_disp = 3'b000;
      return;
    end
    if (m_fault && clr_fault) begin
      m_fault = 0;
      m_streak = 0;
    end else if (m_pv && !m_fault) begin
      if (m_pmm) begin
        m_streak++;
        if (m_streak >= THR) m_fault = 1;
      end else begin
        m_streak = 0;
      end
    end
    if (m_pv && m_pmm) m_err++;
    m_pv  = in_valid;
    m_pmm = in_valid && (cmp3(a0, b0) != cmp3(a1, b1));
    if (in_valid) m_disp = m_fault ? 3'b000 : cmp3(a0, b0);
  endtask

  function automatic logic [17:0] got_vec();
    return {out_valid, lt, gt, eq, mismatch, fault,
            state, err_cnt, err2};
  endfunction

  task automatic check(input string nm, input logic [17:0] exp);
    logic [17:0] got;
    got = got_vec();
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got ov,lt,gt,eq,mm,flt,st,err,err2=%b required %b",
               nm, got, exp);
    end
  endtask

  function automatic logic [17:0] model_vec();
    logic [1:0] st;
    st = m_fault ? 2'd2 : (m_streak > 0 ? 2'd1 : 2'd0);
    return {m_pv, m_disp, m_pmm, m_fault, st,
            8'(m_err), 2'(min3(m_err))};
  endfunction

  task automatic cyc(input logic r, input logic iv,
                     input logic [3:0] x0, input logic [3:0] y0,
                     input logic [3:0] x1, input logic [3:0] y1,
                     input logic c);
    reset = r; in_valid = iv;
    a0 = x0; b0 = y0; a1 = x1; b1 = y1;
    clr_fault = c;
    @(posedge clk);
    model_step();
    #1;
    check("model", model_vec());
  endtask

  typedef struct {
    logic       rst, iv;
    logic [3:0] a0, b0, a1, b1;
    logic       clr;
    logic       ov, lt, gt, eq, mm;
    logic [1:0] st;
    int         err;
  } vec_t;

  function automatic vec_t v(
      input logic r, input logic iv,
      input int x0, input int y0, input int x1, input int y1,
      input logic c,
      input logic ov, input logic l, input logic g, input logic e,
      input logic mm, input int st, input int err);
    vec_t t;
    t.rst = r; t.iv = iv;
    t.a0 = 4'(x0); t.b0 = 4'(y0); t.a1 = 4'(x1); t.b1 = 4'(y1);
    t.clr = c; t.ov = ov; t.lt = l; t.gt = g; t.eq = e;
    t.mm = mm; t.st = 2'(st); t.err = err;
    return t;
  endfunction

  vec_t tbl[24];

  initial begin
    n_chk = 0; n_fail = 0;
    m_fault = 0; m_streak = 0; m_err = 0;
    m_pv = 0; m_pmm = 0; m_disp = 3'b000;
    reset = 1'b0; in_valid = 1'b0; clr_fault = 1'b0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0;

    //            r  iv a0 b0 a1 b1 clr ov lt gt eq mm st err
    tbl[0]  = v(0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = v(1, 1, 5, 9, 5, 9,  0,  1, 1, 0, 0, 0, 0, 0);
    tbl[2]  = v(1, 0, 0, 0, 0, 0,  0,  0, 1, 0, 0, 0, 0, 0);
    tbl[3]  = v(1, 1, 3, 7,12, 7,  0,  1, 1, 0, 0, 1, 0, 0);
    tbl[4]  = v(1, 1, 3, 7,12, 7,  0,  1, 1, 0, 0, 1, 1, 1);
    tbl[5]  = v(1, 1, 3, 7,12, 7,  0,  1, 1, 0, 0, 1, 1, 2);
    tbl[6]  = v(1, 0, 0, 0, 0, 0,  0,  0, 1, 0, 0, 0, 2, 3);
    tbl[7]  = v(1, 1, 5, 9, 5, 9,  0,  1, 0, 0, 0, 0, 2, 3);
    tbl[8]  = v(1, 1, 3, 7,12, 7,  0,  1, 0, 0, 0, 1, 2, 3);
    tbl[9]  = v(1, 0, 0, 0, 0, 0,  1,  0, 0, 0, 0, 0, 0, 4);
    tbl[10] = v(1, 1, 3, 7,12, 7,  0,  1, 1, 0, 0, 1, 0, 4);
    tbl[11] = v(1, 1, 3, 7,12, 7,  0,  1, 1, 0, 0, 1, 1, 5);
    tbl[12] = v(1, 1, 5, 9, 5, 9,  0,  1, 1, 0, 0, 0, 1, 6);
    tbl[13] = v(1, 1, 3, 7,12, 7,  0,  1, 1, 0, 0, 1, 0, 6);
    tbl[14] = v(1, 0, 0, 0, 0, 0,  0,  0, 1, 0, 0, 0, 1, 7);
    tbl[15] = v(1, 0, 0, 0, 0, 0,  0,  0, 1, 0, 0, 0, 1, 7);
    tbl[16] = v(1, 0, 0, 0, 0, 0,  1,  0, 1, 0, 0, 0, 1, 7);
    tbl[17] = v(1, 1, 3, 7,12, 7,  0,  1, 1, 0, 0, 1, 1, 7);
    tbl[18] = v(1, 1, 3, 7,12, 7,  0,  1, 1, 0, 0, 1, 1, 8);
    tbl[19] = v(1, 1, 3, 7,12, 7,  0,  1, 0, 0, 0, 1, 2, 9);
    tbl[20] = v(0, 1, 3, 7,12, 7,  0,  0, 0, 0, 0, 0, 0, 0);
    tbl[21] = v(1, 1, 9, 2, 9, 2,  0,  1, 0, 1, 0, 0, 0, 0);
    tbl[22] = v(1, 1, 6, 6, 6, 6,  0,  1, 0, 0, 1, 0, 0, 0);
    tbl[23] = v(1, 0, 0, 0, 0, 0,  0,  0, 0, 0, 1, 0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      logic [17:0] exp;
      cyc(tbl[i].rst, tbl[i].iv, tbl[i].a0, tbl[i].b0,
          tbl[i].a1, tbl[i].b1, tbl[i].clr);
      exp = {tbl[i].ov, tbl[i].lt, tbl[i].gt, tbl[i].eq, tbl[i].mm,
             tbl[i].st == 2'd2, tbl[i].st,
             8'(tbl[i].err), 2'(min3(tbl[i].err))};
      check($sformatf("tbl[%0d]", i), exp);
    end

    // saturation of the narrow counter with clears in between
    for (int k = 0; k < 6; k++) begin
      cyc(1, 1, 3, 7, 12, 7, 0);
      cyc(1, 0, 0, 0, 0, 0, (k % 2) == 1);
    end
    cyc(1, 0, 0, 0, 0, 0, 0);
    n_chk++;
    if (err2 !== 2'd3) begin
      n_fail++;
      $display("FAIL sat_err2: got %0d required 3", err2);
    end

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic       r, iv, c;
      logic [3:0] x0, y0, x1, y1;
      r  = ($urandom_range(0, 49) != 0);
      iv = ($urandom_range(0, 9) < 7);
      c  = ($urandom_range(0, 9) == 0);
      x0 = 4'($urandom_range(0, 15));
      y0 = 4'($urandom_range(0, 15));
      x1 = x0;
      y1 = y0;
      if ($urandom_range(0, 1) == 1) begin
        x1 = 4'($urandom_range(0, 15));
        y1 = 4'($urandom_range(0, 15));
      end
      cyc(r, iv, x0, y0, x1, y1, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lockstep_cmp_checker.md
LOCKSTEP_CMP_CHECKER -- requirements
Module: lockstep_cmp_checker

Interface
REQ-001 Parameter WIDTH, default 4: operand width of each redundant channel, in bits; legal range 1..32.
REQ-002 Parameter FAULT_THRESH, default 3: number of consecutive mismatching valid samples that escalates to FAULT; legal range 1..15.
REQ-003 Parameter ERR_CNT_W, default 8: width of the mismatch event counter, in bits.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 in_valid  input  1  operands on a0/b0/a1/b1 are sampled on this cycle.
REQ-007 a0, b0  input  WIDTH  channel-0 operands, unsigned.
REQ-008 a1, b1  input  WIDTH  channel-1 operands (redundant copy), unsigned.
REQ-009 clr_fault  input  1  single-cycle request to leave FAULT.
REQ-010 out_valid  output  1  result qualifier.
REQ-011 lt, gt, eq  output  1 each  channel-0 compare result.
REQ-012 mismatch  output  1  channel results disagree on this sample.
REQ-013 fault  output  1  sticky fault flag.
REQ-014 err_cnt  output  ERR_CNT_W  saturating count of mismatching samples.
REQ-015 state  output  2  FSM encoding: OK=0, SUSPECT=1, FAULT=2; 3 is unused.

Function
REQ-016 Each channel SHALL compute {lt,gt,eq} as an unsigned compare; exactly one bit is set per channel.
REQ-017 in_valid=1 at cycle t SHALL give out_valid=1 at t+1, with lt/gt/eq/mismatch registered from the t operands; latency is 1.
REQ-018 in_valid=0 at t SHALL give out_valid=0 and mismatch=0 at t+1, with lt/gt/eq holding their previous values.
REQ-019 mismatch SHALL be the OR of the bitwise XOR of the channel-0 and channel-1 {lt,gt,eq} vectors.
REQ-020 The FSM, run counter and err_cnt SHALL update only on cycles where out_valid=1, with new values visible the following cycle.
REQ-021 OK state, mismatch: run=1; if FAULT_THRESH=1 go to FAULT, else go to SUSPECT.
REQ-022 SUSPECT state, mismatch: increment run; when run reaches FAULT_THRESH go to FAULT.
REQ-023 SUSPECT state, matching valid sample: run=0; go to OK.
REQ-024 FAULT SHALL be sticky; the only exits are clr_fault=1 or reset.
REQ-025 FAULT state, clr_fault=1: go to OK and clear run; clr_fault takes effect on any cycle, regardless of out_valid.
REQ-026 clr_fault=1 in OK or SUSPECT SHALL have no effect.
REQ-027 clr_fault and a mismatch in the same cycle: clr_fault wins; state goes to OK and run=0. err_cnt still increments.
REQ-028 fault SHALL equal (state==FAULT).
REQ-029 In FAULT, lt/gt/eq SHALL be forced to 0 whenever out_valid=1. out_valid and mismatch continue to operate.
REQ-030 err_cnt SHALL increment by 1 per mismatching valid sample and saturate at 2^ERR_CNT_W-1 with no wrap; clr_fault does not clear it.
REQ-031 The run counter SHALL be 4 bits wide and never exceed FAULT_THRESH.

Reset
REQ-032 reset=0 at a rising edge SHALL set the following, overriding all other inputs including a sample in flight:
- out_valid=0, lt=0, gt=0, eq=0, mismatch=0
- fault=0, state=OK, run=0, err_cnt=0
REQ-033 Reset asserted mid-SUSPECT or mid-FAULT SHALL discard the history. The first in_valid after reset=1 SHALL produce out_valid one cycle later.

Verification
REQ-034 Match path: a0=a1=5, b0=b1=9, in_valid pulse -> next cycle out_valid=1, lt=1, gt=0, eq=0, mismatch=0, state=OK.
REQ-035 Escalation: 3 consecutive valid samples with a0=3, a1=12, b0=b1=7, FAULT_THRESH=3 -> mismatch=1 on each sample; state 0->1->1->2; fault=1 the cycle after the 3rd mismatch; err_cnt=3; lt/gt/eq=0 on later samples.
REQ-036 Recovery: 2 mismatches, then 1 matching sample -> state returns to OK, run=0, err_cnt=2. A subsequent single mismatch -> SUSPECT, not FAULT.
REQ-037 Clear race: in FAULT, clr_fault=1 in the same cycle out_valid=1 and mismatch=1 -> next cycle state=OK, fault=0, err_cnt incremented.
REQ-038 Saturation: ERR_CNT_W=2, 6 mismatching samples with clr_fault pulses in between -> err_cnt stops at 3.
REQ-039 Reset: reset=0 asserted while in FAULT with in_valid=1 -> next cycle all outputs 0 and state=OK.
